// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, byte-enable lanes.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // Size 2'b11 falls into the word rule.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface mem_stage_if #(parameter int AW = 32);
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_ack;

    modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                    input  dm_rdata, dm_ack);
    modport slave  (input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                    output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/half lane by address and sign/zero extends.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr, 3'b000} +: 8];
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    data = {{24{sext & w_byte[7]}}, w_byte};
            SZ_H:    data = {{16{sext & w_half[15]}}, w_half};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage plus MEM/WB register; issues loads/stores over a req/ack port
// and stalls upstream until the access completes.
module mem_stage
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          clk,
    input  logic          clrn,
    input  logic          e_valid,
    input  logic          e_wreg,
    input  logic          e_m2reg,
    input  logic          e_wmem,
    input  logic [1:0]    e_size,
    input  logic          e_sext,
    input  logic [4:0]    e_rn,
    input  logic [DW-1:0] e_alu,
    input  logic [DW-1:0] e_b,
    output logic          mem_stall,
    output logic [DW-1:0] r_alu,
    output logic [DW-1:0] m_o,
    output logic          m2reg,
    output logic          wwreg,
    output logic [4:0]    wrn,
    output logic          mis_align,
    mem_stage_if.master   dm
);
    state_t      r_state, w_next;
    logic        w_memop, w_misal, w_issue;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ldata;

    assign w_memop = e_valid & (e_m2reg | e_wmem);
    assign w_misal = misaligned(e_size, e_alu[1:0]);
    assign w_issue = (r_state == ST_IDLE) & w_memop & ~w_misal;

    always_comb begin
        w_be    = BE_W;
        w_wdata = e_b;
        case (e_size)
            SZ_B: begin
                w_be    = BE_B << e_alu[1:0];
                w_wdata = {4{e_b[7:0]}};
            end
            SZ_H: begin
                w_be    = e_alu[1] ? BE_HHI : BE_HLO;
                w_wdata = {2{e_b[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_align (
        .rdata (dm.dm_rdata),
        .addr  (e_alu[1:0]),
        .size  (e_size),
        .sext  (e_sext),
        .data  (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        case (r_state)
            ST_IDLE: if (w_issue) begin
                w_next    = ST_WAIT;
                mem_stall = 1'b1;
            end
            ST_WAIT: begin
                mem_stall = ~dm.dm_ack;
                if (dm.dm_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields are frozen for the whole WAIT period; upstream holds e_* anyway.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_be    <= '0;
            dm.dm_wdata <= '0;
        end else if (w_issue) begin
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= e_wmem;
            dm.dm_addr  <= AW'({e_alu[31:2], 2'b00});
            dm.dm_be    <= w_be;
            dm.dm_wdata <= w_wdata;
        end else if (r_state == ST_WAIT && dm.dm_ack) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_alu     <= '0;
            m_o       <= '0;
            m2reg     <= 1'b0;
            wwreg     <= 1'b0;
            wrn       <= '0;
            mis_align <= 1'b0;
        end else begin
            r_alu     <= e_alu;
            wrn       <= e_rn;
            m_o       <= '0;
            m2reg     <= 1'b0;
            wwreg     <= 1'b0;
            mis_align <= 1'b0;
            if (r_state == ST_IDLE) begin
                wwreg     <= e_valid & e_wreg & ~w_memop;
                mis_align <= w_memop & w_misal;
            end else if (dm.dm_ack) begin
                m2reg <= e_m2reg;
                wwreg <= e_wreg & e_m2reg;
                m_o   <= e_m2reg ? w_ldata : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: cycle-level reference model plus literal spot checks.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0, clrn = 1'b0;
    logic        e_valid = 0, e_wreg = 0, e_m2reg = 0, e_wmem = 0, e_sext = 0;
    logic [1:0]  e_size = 0;
    logic [4:0]  e_rn = 0;
    logic [31:0] e_alu = 0, e_b = 0;
    logic        mem_stall, m2reg, wwreg, mis_align;
    logic [31:0] r_alu, m_o;
    logic [4:0]  wrn;

    mem_stage_if #(.AW(32)) dm();

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .clrn(clrn), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
        .e_wmem(e_wmem), .e_size(e_size), .e_sext(e_sext), .e_rn(e_rn), .e_alu(e_alu),
        .e_b(e_b), .mem_stall(mem_stall), .r_alu(r_alu), .m_o(m_o), .m2reg(m2reg),
        .wwreg(wwreg), .wrn(wrn), .mis_align(mis_align), .dm(dm)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] s, input logic sx);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (nbytes(s) == 1) begin
            v = v & 32'hFF;
            if (sx && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (nbytes(s) == 2) begin
            v = v & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // Reference model: one access in flight at most; WB result computed from the rules.
    bit          m_busy = 0, chk_en = 0;
    bit          x_m2reg = 0, x_wwreg = 0, x_req = 0, x_we = 0, x_mis = 0;
    logic [31:0] x_alu = 0, x_mo = 0, x_addr = 0, x_wdata = 0;
    logic [3:0]  x_be = 0;
    logic [4:0]  x_wrn = 0;
    int          mn;
    bit          mmemop, mmis;

    always @(posedge clk) begin
        mn     = nbytes(e_size);
        mmemop = e_valid && (e_m2reg || e_wmem);
        mmis   = (e_alu % mn) != 0;
        if (!clrn) begin
            m_busy = 0; x_m2reg = 0; x_wwreg = 0; x_req = 0; x_we = 0; x_mis = 0;
            x_alu = 0; x_mo = 0; x_wrn = 0;
        end else if (!m_busy) begin
            x_mis = mmemop && mmis;
            x_alu = e_alu; x_wrn = e_rn; x_m2reg = 0; x_mo = 0;
            x_wwreg = e_valid && e_wreg && !mmemop;
            if (mmemop && !mmis) begin
                m_busy  = 1; x_req = 1; x_we = e_wmem;
                x_addr  = e_alu & ~32'd3;
                x_be    = 4'(((1 << mn) - 1) << (e_alu % 4));
                x_wdata = (mn == 1) ? (e_b & 32'hFF) * 32'h01010101 :
                          (mn == 2) ? (e_b & 32'hFFFF) * 32'h00010001 : e_b;
            end
        end else begin
            x_mis = 0; x_m2reg = 0; x_wwreg = 0;
            if (dm.dm_ack) begin
                m_busy = 0; x_req = 0;
                x_alu = e_alu; x_wrn = e_rn; x_m2reg = e_m2reg;
                x_wwreg = e_wreg && e_m2reg;
                x_mo = e_m2reg ? ld_val(dm.dm_rdata, e_alu, e_size, e_sext) : 32'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall", mem_stall,
                  m_busy ? !dm.dm_ack
                         : (e_valid && (e_m2reg || e_wmem) && (e_alu % nbytes(e_size)) == 0));
            check("dm_req", dm.dm_req, x_req);
            check("mis_align", mis_align, x_mis);
            check("wwreg", wwreg, x_wwreg);
            check("m2reg", m2reg, x_m2reg);
            if (x_wwreg || x_m2reg) begin
                check("r_alu", r_alu, x_alu);
                check("wrn", wrn, x_wrn);
                check("m_o", m_o, x_mo);
            end
            if (x_req) begin
                check("dm_we", dm.dm_we, x_we);
                check("dm_addr", dm.dm_addr, x_addr);
                check("dm_be", dm.dm_be, x_be);
                if (x_we) check("dm_wdata", dm.dm_wdata, x_wdata);
            end
        end
    end

    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    // Presents one instruction; ack_dly = WAIT cycles up to and including the ack cycle.
    task automatic run_op(input logic v, wr, m2r, wm, input logic [1:0] sz, input logic sx,
                          input logic [4:0] rn, input logic [31:0] alu, b,
                          input int ack_dly, input logic [31:0] rd,
                          output int ncyc, output int nstall);
        e_valid = v; e_wreg = wr; e_m2reg = m2r; e_wmem = wm; e_size = sz; e_sext = sx;
        e_rn = rn; e_alu = alu; e_b = b;
        ncyc = 1; nstall = 0;
        #1 if (mem_stall) nstall++;
        @(posedge clk); #2;
        if (dm.dm_req) begin
            cap_we = dm.dm_we; cap_be = dm.dm_be; cap_addr = dm.dm_addr; cap_wdata = dm.dm_wdata;
            for (int i = 1; i < ack_dly; i++) begin
                ncyc++;
                #1 if (mem_stall) nstall++;
                @(posedge clk); #2;
            end
            dm.dm_ack = 1'b1; dm.dm_rdata = rd; ncyc++;
            #1 if (mem_stall) nstall++;
            @(posedge clk); #2;
            dm.dm_ack = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        e_valid = 0; e_wreg = 0; e_m2reg = 0; e_wmem = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    int nc, ns;

    initial begin
        dm.dm_ack = 1'b0; dm.dm_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst r_alu", r_alu, 0); check("rst m_o", m_o, 0); check("rst wwreg", wwreg, 0);
        check("rst dm_req", dm.dm_req, 0); check("rst dm_be", dm.dm_be, 0);
        clrn = 1'b1; chk_en = 1;

        // ALU op
        run_op(1, 1, 0, 0, SZ_W, 0, 5'd5, 32'h1234, 0, 1, 0, nc, ns);
        check("alu r_alu", r_alu, 32'h1234); check("alu wwreg", wwreg, 1);
        check("alu wrn", wrn, 5); check("alu m2reg", m2reg, 0);
        check("alu stall", ns, 0); check("alu req", dm.dm_req, 0);

        // LB signed, ack in 4th WAIT cycle
        run_op(1, 1, 1, 0, SZ_B, 1, 5'd7, 32'h103, 0, 4, 32'h80112233, nc, ns);
        check("lb m_o", m_o, 32'hFFFFFF80); check("lb m2reg", m2reg, 1);
        check("lb wwreg", wwreg, 1); check("lb stall cycles", ns, 4);
        check("lb be", cap_be, 4'b1000); check("lb we", cap_we, 0);
        check("lb req drop", dm.dm_req, 0);

        // SH, ack in first WAIT cycle
        run_op(1, 0, 0, 1, SZ_H, 0, 5'd0, 32'h102, 32'h0000ABCD, 1, 0, nc, ns);
        check("sh we", cap_we, 1); check("sh be", cap_be, 4'b1100);
        check("sh wdata", cap_wdata, 32'hABCDABCD); check("sh addr", cap_addr, 32'h100);
        check("sh wwreg", wwreg, 0); check("sh latency", nc, 2);

        // LW misaligned
        run_op(1, 1, 1, 0, SZ_W, 0, 5'd3, 32'h101, 0, 1, 0, nc, ns);
        check("mis pulse", mis_align, 1); check("mis wwreg", wwreg, 0);
        check("mis req", dm.dm_req, 0); check("mis stall", ns, 0);
        idle(1);
        check("mis pulse end", mis_align, 0);

        // Reset during WAIT, then a late ack
        e_valid = 1; e_wreg = 1; e_m2reg = 1; e_wmem = 0; e_size = SZ_W; e_rn = 9;
        e_alu = 32'h300;
        @(posedge clk); #2;
        check("rst-wait req", dm.dm_req, 1);
        @(posedge clk); #2;
        clrn = 1'b0;
        @(posedge clk); #2;
        check("mid rst req", dm.dm_req, 0); check("mid rst we", dm.dm_we, 0);
        check("mid rst be", dm.dm_be, 0); check("mid rst addr", dm.dm_addr, 0);
        check("mid rst wdata", dm.dm_wdata, 0); check("mid rst r_alu", r_alu, 0);
        check("mid rst wrn", wrn, 0); check("mid rst wwreg", wwreg, 0);
        clrn = 1'b1; e_valid = 0; e_wreg = 0; e_m2reg = 0;
        dm.dm_ack = 1'b1; dm.dm_rdata = 32'hDEADBEEF;
        @(posedge clk); #2;
        dm.dm_ack = 1'b0;
        check("late ack wwreg", wwreg, 0); check("late ack m2reg", m2reg, 0);
        check("late ack req", dm.dm_req, 0);

        // Back-to-back LHU
        run_op(1, 1, 1, 0, SZ_H, 0, 5'd4, 32'h200, 0, 1, 32'hBEEF8001, nc, ns);
        check("lhu0 m_o", m_o, 32'h00008001); check("lhu0 cycles", nc, 2);
        run_op(1, 1, 1, 0, SZ_H, 0, 5'd4, 32'h202, 0, 1, 32'hBEEF8001, nc, ns);
        check("lhu1 m_o", m_o, 32'h0000BEEF); check("lhu1 cycles", nc, 2);

        idle(2);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
